// File: rtl/dpe_pkg.sv
// ============================================================================
// dpe_pkg : shared sizing helpers for the dot-product engine
// Revision: 1.0
// ============================================================================
`default_nettype none

package dpe_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int calc_ow(input int dw, input int lanes, input int max_beats);
    return 2 * dw + clog2(lanes) + clog2(max_beats) + 1;
  endfunction

  // Lane 0 occupies the most significant slice of a packed lane vector.
  function automatic int lane_lsb(input int k, input int width, input int lanes);
    return (lanes - 1 - k) * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpe_adder_tree.sv
// ============================================================================
// dpe_adder_tree : registered pairwise reduction with valid/last/mode sideband
// Revision: 1.0
// ============================================================================
`default_nettype none

module dpe_adder_tree
  import dpe_pkg::*;
#(
  parameter int LANES = 32,
  parameter int WIDTH = 8,
  localparam int SW = WIDTH + clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic                   last_i,
  input  logic                   mode_i,
  input  logic [LANES*WIDTH-1:0] data_i,
  output logic                   valid_o,
  output logic                   last_o,
  output logic                   mode_o,
  output logic [SW-1:0]          sum_o
);

  localparam int LVLS = clog2(LANES);

  // Heap layout: node n sums children 2n and 2n+1, leaves sit at LANES+k, so
  // every level pairs adjacent lanes. Leaves are pre-extended to the full
  // result width, which keeps each level's sum exact for either mode.
  logic [SW-1:0]   node_w [1:2*LANES-1];
  logic [LVLS-1:0] vld_q;
  logic [LVLS-1:0] lst_q;
  logic [LVLS-1:0] mod_q;

  genvar k, n;
  generate
    for (k = 0; k < LANES; k++) begin : g_leaf
      localparam int LSB = lane_lsb(k, WIDTH, LANES);
      assign node_w[LANES+k] = {{LVLS{mode_i & data_i[LSB+WIDTH-1]}}, data_i[LSB +: WIDTH]};
    end

    for (n = 1; n < LANES; n++) begin : g_node
      logic [SW-1:0] sum_q;
      always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else     sum_q <= node_w[2*n] + node_w[2*n+1];
      end
      assign node_w[n] = sum_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      lst_q <= '0;
      mod_q <= '0;
    end else begin
      vld_q[0] <= valid_i;
      lst_q[0] <= last_i;
      mod_q[0] <= mode_i;
      for (int s = 1; s < LVLS; s++) begin
        vld_q[s] <= vld_q[s-1];
        lst_q[s] <= lst_q[s-1];
        mod_q[s] <= mod_q[s-1];
      end
    end
  end

  assign sum_o   = node_w[1];
  assign valid_o = vld_q[LVLS-1];
  assign last_o  = lst_q[LVLS-1];
  assign mode_o  = mod_q[LVLS-1];

endmodule

`default_nettype wire

// File: rtl/dot_product_engine.sv
// ============================================================================
// dot_product_engine : pipelined multi-beat integer dot product with overflow flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module dot_product_engine
  import dpe_pkg::*;
#(
  parameter int LANES     = 32,
  parameter int DW        = 4,
  parameter int MAX_BEATS = 4,
  localparam int OW = calc_ow(DW, LANES, MAX_BEATS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic                signed_mode,
  input  logic [LANES*DW-1:0] I,
  input  logic                weight_valid,
  input  logic [LANES*DW-1:0] W,
  output logic                out_valid,
  output logic [OW-1:0]       OUT,
  output logic                out_ovf
);

  localparam int PW = 2 * DW;
  localparam int TW = PW + clog2(LANES);
  localparam int CW = clog2(MAX_BEATS) + 2;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS + 1);
  localparam logic [CW-1:0] OVF_LIM = CW'(MAX_BEATS);

  logic [LANES*DW-1:0] wbank_q, w_eff;
  logic [LANES*PW-1:0] prod_d, prod_q;
  logic                p_valid_q, p_last_q, p_mode_q;
  logic                t_valid, t_last, t_mode;
  logic [TW-1:0]       t_sum;
  logic [OW-1:0]       part_ext, acc_d, acc_q;
  logic [CW-1:0]       cnt_d, cnt_q;
  logic                fresh_d, fresh_q, fire_q;
  logic                out_valid_q, out_ovf_q;
  logic [OW-1:0]       out_q;

  // A weight load in the same cycle as a beat is used by that beat directly.
  assign w_eff = weight_valid ? W : wbank_q;

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      localparam int IL = lane_lsb(k, DW, LANES);
      localparam int PL = lane_lsb(k, PW, LANES);
      logic [PW-1:0] a_ext, b_ext;
      assign a_ext = {{DW{signed_mode & I[IL+DW-1]}}, I[IL +: DW]};
      assign b_ext = {{DW{signed_mode & w_eff[IL+DW-1]}}, w_eff[IL +: DW]};
      assign prod_d[PL +: PW] = a_ext * b_ext;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank_q   <= '0;
      prod_q    <= '0;
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_mode_q  <= 1'b0;
    end else begin
      if (weight_valid) wbank_q <= W;
      prod_q    <= prod_d;
      p_valid_q <= in_valid;
      p_last_q  <= in_valid & in_last;
      p_mode_q  <= signed_mode;
    end
  end

  dpe_adder_tree #(
    .LANES (LANES),
    .WIDTH (PW)
  ) u_tree (
    .clk     (clk),
    .rst     (rst),
    .valid_i (p_valid_q),
    .last_i  (p_last_q),
    .mode_i  (p_mode_q),
    .data_i  (prod_q),
    .valid_o (t_valid),
    .last_o  (t_last),
    .mode_o  (t_mode),
    .sum_o   (t_sum)
  );

  assign part_ext = {{(OW-TW){t_mode & t_sum[TW-1]}}, t_sum};

  // fresh_q marks that the next beat opens a new vector.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    fresh_d = fresh_q;
    if (t_valid) begin
      fresh_d = t_last;
      if (fresh_q) begin
        acc_d = part_ext;
        cnt_d = CW'(1);
      end else begin
        acc_d = acc_q + part_ext;
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      fresh_q     <= 1'b1;
      fire_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      fresh_q     <= fresh_d;
      fire_q      <= t_valid & t_last;
      out_valid_q <= fire_q;
      out_q       <= fire_q ? acc_q : '0;
      out_ovf_q   <= fire_q & (cnt_q > OVF_LIM);
    end
  end

  assign out_valid = out_valid_q;
  assign OUT       = out_q;
  assign out_ovf   = out_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_product_engine.sv
// ============================================================================
// tb_dot_product_engine : scoreboard bench with an arithmetic reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dot_product_engine;

  localparam int LANES     = 32;
  localparam int DW        = 4;
  localparam int MAX_BEATS = 4;
  localparam int OW        = 16;
  localparam int LAT       = 7;
  localparam int VW        = LANES * DW;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_last, signed_mode, weight_valid;
  logic [VW-1:0] I, W;
  logic          out_valid, out_ovf;
  logic [OW-1:0] OUT;

  always #5 clk = ~clk;

  dot_product_engine #(
    .LANES     (LANES),
    .DW        (DW),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .signed_mode  (signed_mode),
    .I            (I),
    .weight_valid (weight_valid),
    .W            (W),
    .out_valid    (out_valid),
    .OUT          (OUT),
    .out_ovf      (out_ovf)
  );

  typedef struct {
    logic [OW-1:0] out;
    logic          ovf;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            checks = 0;
  int            passes = 0;
  bit            mon_en = 1'b0;
  logic [VW-1:0] m_bank;
  longint        m_acc;
  int            m_cnt;
  bit            m_fresh;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int lane_val(input logic [VW-1:0] v, input int k, input bit s);
    logic [DW-1:0] x;
    x = v[(LANES-1-k)*DW +: DW];
    return (s && x[DW-1]) ? int'(x) - (1 << DW) : int'(x);
  endfunction

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] x);
    return {LANES{x}};
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // Monitor: pops one expectation per out_valid pulse; idle cycles must be all-zero.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("OUT", 32'(OUT), 32'(e.out));
          chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
          chk("latency_cycle", cyc, e.cyc);
        end
      end else begin
        chk("idle_outputs", 32'({out_valid, out_ovf, OUT}), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit stray_last);
    in_valid     = 1'b0;
    in_last      = stray_last;
    weight_valid = 1'b0;
    I            = rand_vec();
    step();
  endtask

  task automatic load_w(input logic [VW-1:0] wv);
    in_valid     = 1'b0;
    in_last      = 1'b0;
    weight_valid = 1'b1;
    W            = wv;
    m_bank       = wv;
    step();
  endtask

  task automatic beat(input logic [VW-1:0] iv, input bit last, input bit s,
                      input bit wv, input logic [VW-1:0] wvec);
    longint p;
    exp_t   e;
    in_valid     = 1'b1;
    I            = iv;
    in_last      = last;
    signed_mode  = s;
    weight_valid = wv;
    W            = wvec;
    if (wv) m_bank = wvec;
    p = 0;
    for (int k = 0; k < LANES; k++)
      p += longint'(lane_val(iv, k, s)) * longint'(lane_val(m_bank, k, s));
    if (m_fresh) begin
      m_acc = p;
      m_cnt = 1;
    end else begin
      m_acc += p;
      m_cnt++;
    end
    m_fresh = last;
    if (last) begin
      e.out = m_acc[OW-1:0];
      e.ovf = (m_cnt > MAX_BEATS);
      e.cyc = cyc + LAT + 1;
      sb.push_back(e);
    end
    step();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    in_valid     = 1'b0;
    weight_valid = 1'b0;
    step();
    sb.delete();
    m_bank  = '0;
    m_fresh = 1'b1;
    rst     = 1'b0;
  endtask

  initial begin
    int len;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; signed_mode = 1'b0;
    weight_valid = 1'b0; I = '0; W = '0;
    m_bank = '0; m_fresh = 1'b1; m_acc = 0; m_cnt = 0;
    step();
    chk("reset_outputs", 32'({out_valid, out_ovf, OUT}), 32'd0);
    mon_en = 1'b1;
    step();
    rst = 1'b0;

    // Unsigned full-scale beat, then signed -1 x 7.
    load_w(fill(4'hF));
    beat(fill(4'hF), 1'b1, 1'b0, 1'b0, '0);
    repeat (LAT + 2) idle(1'b0);
    load_w(fill(4'h7));
    beat(fill(4'hF), 1'b1, 1'b1, 1'b0, '0);
    repeat (LAT + 2) idle(1'b0);

    // Three-beat vector then an immediate one-beat vector.
    load_w(fill(4'h1));
    beat(fill(4'h1), 1'b0, 1'b0, 1'b0, '0);
    beat(fill(4'h1), 1'b0, 1'b0, 1'b0, '0);
    beat(fill(4'h1), 1'b1, 1'b0, 1'b0, '0);
    beat(fill(4'h2), 1'b1, 1'b0, 1'b0, '0);
    repeat (LAT + 2) idle(1'b0);

    // Weight bypass, then the new bank retained.
    beat(fill(4'h1), 1'b1, 1'b0, 1'b1, fill(4'h2));
    beat(fill(4'h1), 1'b1, 1'b0, 1'b0, '0);
    repeat (LAT + 2) idle(1'b0);

    // Five beats: exceeds MAX_BEATS.
    load_w(fill(4'h1));
    for (int b = 0; b < 5; b++) beat(fill(4'h1), b == 4, 1'b0, 1'b0, '0);
    repeat (LAT + 2) idle(1'b0);

    // Reset with a vector in flight, then a beat against the cleared bank.
    beat(fill(4'h1), 1'b0, 1'b0, 1'b0, '0);
    beat(fill(4'h1), 1'b1, 1'b0, 1'b0, '0);
    idle(1'b0);
    idle(1'b0);
    do_reset();
    repeat (LAT + 2) idle(1'b0);
    beat(fill(4'h1), 1'b1, 1'b0, 1'b0, '0);
    repeat (LAT + 2) idle(1'b0);

    // Random vectors: mixed modes, gaps, stray in_last, bypass and bank loads.
    for (int v = 0; v < 80; v++) begin
      len = $urandom_range(1, 6);
      if ($urandom_range(0, 5) == 0) load_w(rand_vec());
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1'($urandom));
        beat(rand_vec(), b == len - 1, 1'($urandom), $urandom_range(0, 7) == 0, rand_vec());
      end
    end

    repeat (LAT + 3) idle(1'b0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
